// File: rtl/layer_scheduler.sv
// Time-multiplexed fully connected layer: one shared MAC walks every neuron, then applies bias and ReLU.
// Optional build macro LAYER_SCHEDULER_SATURATE_EN clamps results instead of truncating them.
module layer_scheduler #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_INPUTS  = 16,
  parameter int unsigned NUM_NEURONS = 8
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic                                                   input_ready,
  input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]                  inputs,
  output logic                                                   weight_rd_en,
  output logic [$clog2(NUM_NEURONS*NUM_INPUTS)-1:0]              weight_addr,
  input  logic signed [DATA_WIDTH-1:0]                           weight_data,
  output logic [(NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1)-1:0] bias_addr,
  input  logic signed [DATA_WIDTH-1:0]                           bias_data,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]                 outputs,
  output logic                                                   output_ready,
  output logic                                                   busy
);

  localparam int unsigned WAW = $clog2(NUM_NEURONS * NUM_INPUTS);
  localparam int unsigned NW  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int unsigned KW  = $clog2(NUM_INPUTS);
  localparam int unsigned PW  = 2 * DATA_WIDTH;
  localparam int unsigned AW  = PW + KW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StMac,
    StActivate,
    StDone
  } state_e;

  state_e                                 state_q, state_d;
  logic [NW-1:0]                          neuron_q, neuron_d;
  logic [KW-1:0]                          k_q, k_d;
  logic signed [AW-1:0]                   acc_q, acc_d;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  in_q, in_d;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] out_q, out_d;
  logic [WAW-1:0]                         waddr_q, waddr_d;

  logic [WAW-1:0]        base_addr;
  logic signed [PW-1:0]  prod;
  logic [AW-1:0]         r_sum;
  logic [AW-1:0]         r_relu;
  logic [DATA_WIDTH-1:0] r_narrow;

  assign base_addr = WAW'(neuron_q) * WAW'(NUM_INPUTS);
  assign prod      = PW'($signed(in_q[k_q])) * PW'(weight_data);
  assign r_sum     = acc_q + {{(AW-DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data};
  assign r_relu    = r_sum[AW-1] ? '0 : r_sum;

`ifdef LAYER_SCHEDULER_SATURATE_EN
  // r_relu is non-negative, so any set bit at DATA_WIDTH-1 or above means it exceeds the max.
  assign r_narrow = (|r_relu[AW-1:DATA_WIDTH-1]) ? {1'b0, {(DATA_WIDTH-1){1'b1}}}
                                                  : DATA_WIDTH'(r_relu);
`else
  assign r_narrow = DATA_WIDTH'(r_relu);
`endif

  always_comb begin
    state_d      = state_q;
    neuron_d     = neuron_q;
    k_d          = k_q;
    acc_d        = acc_q;
    in_d         = in_q;
    out_d        = out_q;
    weight_rd_en = 1'b0;
    weight_addr  = waddr_q;

    unique case (state_q)
      StIdle: begin
        if (input_ready) begin
          in_d     = inputs;
          neuron_d = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        weight_rd_en = 1'b1;
        weight_addr  = base_addr;
        acc_d        = '0;
        k_d          = '0;
        state_d      = StMac;
      end
      StMac: begin
        acc_d = acc_q + {{(AW-PW){prod[PW-1]}}, prod};
        if (k_q != KW'(NUM_INPUTS - 1)) begin
          // Prefetch the next weight so it arrives exactly when k advances.
          weight_rd_en = 1'b1;
          weight_addr  = base_addr + WAW'(k_q) + WAW'(1);
          k_d          = k_q + KW'(1);
        end else begin
          state_d = StActivate;
        end
      end
      StActivate: begin
        out_d[neuron_q] = r_narrow;
        if (neuron_q == NW'(NUM_NEURONS - 1)) begin
          state_d = StDone;
        end else begin
          neuron_d = neuron_q + NW'(1);
          state_d  = StFetch;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    waddr_d = weight_addr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      neuron_q <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      in_q     <= '0;
      out_q    <= '0;
      waddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      neuron_q <= neuron_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      in_q     <= in_d;
      out_q    <= out_d;
      waddr_q  <= waddr_d;
    end
  end

  assign bias_addr    = neuron_q;
  assign outputs      = out_q;
  assign output_ready = (state_q == StDone);
  assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_layer_scheduler.sv
// Directed and randomized checks of layer_scheduler against an arithmetic reference of the layer.
module tb_layer_scheduler;

  localparam int DW = 32;
  localparam int NI = 4;
  localparam int NN = 2;

  logic                   clock;
  logic                   reset;
  logic                   input_ready;
  logic [NI-1:0][DW-1:0]  inputs;
  logic                   weight_rd_en;
  logic [2:0]             weight_addr;
  logic signed [DW-1:0]   weight_data;
  logic [0:0]             bias_addr;
  logic signed [DW-1:0]   bias_data;
  logic [NN-1:0][DW-1:0]  outputs;
  logic                   output_ready;
  logic                   busy;

  layer_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .NUM_NEURONS(NN)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .input_ready (input_ready),
    .inputs      (inputs),
    .weight_rd_en(weight_rd_en),
    .weight_addr (weight_addr),
    .weight_data (weight_data),
    .bias_addr   (bias_addr),
    .bias_data   (bias_data),
    .outputs     (outputs),
    .output_ready(output_ready),
    .busy        (busy)
  );

  logic signed [DW-1:0]  w_mem [NN*NI];
  logic signed [DW-1:0]  b_mem [NN];
  logic [NN-1:0][DW-1:0] exp_out;
  logic [NI-1:0][DW-1:0] vec;
  int                    trace_w[$];
  int                    trace_b[$];
  int                    n_vec = 0;
  int                    n_err = 0;
  int                    cyc;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous-read memories outside the DUT.
  always @(posedge clock) if (weight_rd_en) weight_data <= w_mem[weight_addr];
  always @(posedge clock) bias_data <= b_mem[bias_addr];

  always @(negedge clock) begin
    if (weight_rd_en) begin
      trace_w.push_back(int'(weight_addr));
      trace_b.push_back(int'(bias_addr));
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dot product, bias, ReLU and narrowing done in wide plain arithmetic.
  function automatic logic [NN-1:0][DW-1:0] model(input logic [NI-1:0][DW-1:0] v);
    logic signed [127:0]   s;
    logic [NN-1:0][DW-1:0] r;
    for (int n = 0; n < NN; n++) begin
      s = 0;
      for (int k = 0; k < NI; k++) s = s + $signed(v[k]) * $signed(w_mem[n*NI+k]);
      s = s + $signed(b_mem[n]);
      if (s < 0) s = 0;
`ifdef LAYER_SCHEDULER_SATURATE_EN
      if (s > ((128'sd1 <<< (DW-1)) - 1)) s = (128'sd1 <<< (DW-1)) - 1;
`endif
      r[n] = s[DW-1:0];
    end
    return r;
  endfunction

  task automatic set_basic(input int bias1);
    for (int i = 0; i < NI; i++) begin
      w_mem[i]    = 1;
      w_mem[NI+i] = -1;
      vec[i]      = DW'(i + 1);
    end
    b_mem[0] = 5;
    b_mem[1] = bias1;
  endtask

  // Returns at the negedge of cycle 1 after the accepting edge.
  task automatic start_job(input logic [NI-1:0][DW-1:0] v, input bit hold);
    @(negedge clock);
    inputs      = v;
    input_ready = 1'b1;
    @(posedge clock);
    exp_out = model(v);
    trace_w.delete();
    trace_b.delete();
    @(negedge clock);
    if (!hold) input_ready = 1'b0;
  endtask

  task automatic finish_job(input string tag);
    cyc = 1;
    while (!output_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(NN*(NI+2)+1));
    for (int n = 0; n < NN; n++) check($sformatf("%s_out%0d", tag, n), 64'(outputs[n]), 64'(exp_out[n]));
    @(negedge clock);
    check({tag, "_ready_pulse"}, 64'(output_ready), 64'(0));
  endtask

  initial begin
    reset       = 1'b0;
    input_ready = 1'b0;
    inputs      = '0;
    for (int i = 0; i < NN*NI; i++) w_mem[i] = 0;
    for (int i = 0; i < NN; i++) b_mem[i] = 0;
    #12;
    check("rst_outputs", 64'(outputs), 64'(0));
    check("rst_ready", 64'(output_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rd_en", 64'(weight_rd_en), 64'(0));
    check("rst_waddr", 64'(weight_addr), 64'(0));
    check("rst_baddr", 64'(bias_addr), 64'(0));
    @(negedge clock);
    reset = 1'b1;

    // Basic layer with address trace.
    set_basic(3);
    start_job(vec, 1'b0);
    finish_job("basic");
    check("basic_busy_after", 64'(busy), 64'(0));
    check("trace_len", 64'(trace_w.size()), 64'(NN*NI));
    for (int i = 0; i < trace_w.size() && i < NN*NI; i++) begin
      check($sformatf("waddr%0d", i), 64'(trace_w[i]), 64'(i));
      check($sformatf("baddr%0d", i), 64'(trace_b[i]), 64'(i / NI));
    end

    // Bias pushes neuron 1 just above and exactly to zero.
    set_basic(11);
    start_job(vec, 1'b0);
    finish_job("bias11");
    set_basic(10);
    start_job(vec, 1'b0);
    finish_job("bias10");

    // Product sum overflows the output width.
    for (int i = 0; i < NN*NI; i++) w_mem[i] = 4;
    for (int i = 0; i < NN; i++) b_mem[i] = 0;
    for (int i = 0; i < NI; i++) vec[i] = 32'h4000_0000;
    start_job(vec, 1'b0);
    finish_job("ovf");

    // Input changes while busy are ignored; held input_ready accepted only after DONE.
    set_basic(3);
    start_job(vec, 1'b1);
    for (int i = 0; i < NI; i++) vec[i] = 9;
    inputs = vec;
    cyc = 1;
    while (!output_ready && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
    check("b2b_latency", 64'(cyc), 64'(NN*(NI+2)+1));
    for (int n = 0; n < NN; n++) check($sformatf("b2b_first%0d", n), 64'(outputs[n]), 64'(exp_out[n]));
    @(negedge clock);
    check("b2b_idle_gap", 64'(busy), 64'(0));
    @(posedge clock);
    exp_out = model(vec);
    @(negedge clock);
    input_ready = 1'b0;
    check("b2b_second_busy", 64'(busy), 64'(1));
    finish_job("b2b_second");

    // Reset in the middle of MAC, then a fresh job.
    set_basic(3);
    start_job(vec, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_outputs", 64'(outputs), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_rd_en", 64'(weight_rd_en), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    start_job(vec, 1'b0);
    finish_job("post_rst");

    // Randomized layers: small signed values, then full-width values.
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < NN*NI; i++)
        w_mem[i] = (t < 5) ? DW'(int'($urandom_range(0, 200)) - 100) : DW'($urandom);
      for (int i = 0; i < NN; i++)
        b_mem[i] = (t < 5) ? DW'(int'($urandom_range(0, 2000)) - 1000) : DW'($urandom);
      for (int i = 0; i < NI; i++)
        vec[i] = (t < 5) ? DW'(int'($urandom_range(0, 200)) - 100) : DW'($urandom);
      start_job(vec, 1'b0);
      finish_job($sformatf("rand%0d", t));
    end

    // Results hold while idle.
    repeat (5) @(negedge clock);
    check("hold_outputs", 64'(outputs), 64'(exp_out));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
